// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Registered 1:2 demultiplexer. Each accepted input word is steered to port A
//   (SEL=0) or port B (SEL=1). Every port owns an independent 2-entry FIFO, so
//   a stalled port never blocks, drops or reorders traffic bound for the other.
//
// Handshake rule (all three interfaces): a word moves across an interface at a
//   rising CLK edge where that interface's VALID and READY are both high.
//   VALID never depends on READY. IN_READY depends only on registered buffer
//   state, SEL and RST, never on A_READY/B_READY.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   IN_DATA/VALID/READY   input stream
//   SEL                   destination select (0 -> A, 1 -> B)
//   A_DATA/VALID/READY    output stream A (head of A buffer, registered)
//   B_DATA/VALID/READY    output stream B (head of B buffer, registered)
//   CNT_A, CNT_B          delivered-word counters, wrap modulo 2^CNT_W
// -----------------------------------------------------------------------------
module stream_demux #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             SEL,
   output logic [WIDTH-1:0] A_DATA,
   output logic             A_VALID,
   input  logic             A_READY,
   output logic [WIDTH-1:0] B_DATA,
   output logic             B_VALID,
   input  logic             B_READY,
   output logic [CNT_W-1:0] CNT_A,
   output logic [CNT_W-1:0] CNT_B
);

   // Per-port buffer occupancy; index 0 is port A, index 1 is port B.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e             occ_q  [2];
   occ_e             occ_d  [2];
   logic [WIDTH-1:0] head_q [2];
   logic [WIDTH-1:0] head_d [2];
   logic [WIDTH-1:0] tail_q [2];
   logic [WIDTH-1:0] tail_d [2];
   logic [CNT_W-1:0] cnt_q  [2];
   logic [CNT_W-1:0] cnt_d  [2];

   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] out_ready;
   logic       in_ready;

   // Acceptance only looks at the buffer SEL points to; the other buffer may
   // be full without stalling the input.
   assign in_ready  = ~RST & (SEL ? (occ_q[1] != OCC_FULL) : (occ_q[0] != OCC_FULL));
   assign IN_READY  = in_ready;
   assign out_ready = {B_READY, A_READY};

   always_comb begin
      push[0] = IN_VALID & in_ready & ~SEL;
      push[1] = IN_VALID & in_ready &  SEL;
      pop     = 2'b00;
      for (int p = 0; p < 2; p++) begin
         occ_d[p]  = occ_q[p];
         head_d[p] = head_q[p];
         tail_d[p] = tail_q[p];
         pop[p]    = (occ_q[p] != OCC_EMPTY) & out_ready[p];
         cnt_d[p]  = cnt_q[p] + {{(CNT_W-1){1'b0}}, pop[p]};
         case (occ_q[p])
            OCC_EMPTY: begin
               if (push[p]) begin
                  occ_d[p]  = OCC_ONE;
                  head_d[p] = IN_DATA;
               end
            end
            OCC_ONE: begin
               if (push[p] && pop[p]) begin
                  // Head leaves and the new word takes its place directly.
                  head_d[p] = IN_DATA;
               end else if (push[p]) begin
                  occ_d[p]  = OCC_FULL;
                  tail_d[p] = IN_DATA;
               end else if (pop[p]) begin
                  // Head register keeps the delivered word as its idle value.
                  occ_d[p]  = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               // No push possible here: in_ready is low for this port.
               if (pop[p]) begin
                  occ_d[p]  = OCC_ONE;
                  head_d[p] = tail_q[p];
               end
            end
            default: begin
               occ_d[p] = OCC_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int p = 0; p < 2; p++) begin
            occ_q[p]  <= OCC_EMPTY;
            head_q[p] <= '0;
            tail_q[p] <= '0;
            cnt_q[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            occ_q[p]  <= occ_d[p];
            head_q[p] <= head_d[p];
            tail_q[p] <= tail_d[p];
            cnt_q[p]  <= cnt_d[p];
         end
      end
   end

   assign A_DATA  = head_q[0];
   assign A_VALID = (occ_q[0] != OCC_EMPTY);
   assign B_DATA  = head_q[1];
   assign B_VALID = (occ_q[1] != OCC_EMPTY);
   assign CNT_A   = cnt_q[0];
   assign CNT_B   = cnt_q[1];

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Bench for stream_demux. A driver applies directed vectors (and a random
//   phase) one cycle at a time; a monitor on the falling edge keeps its own
//   model of both port buffers (expected-word queues), checks every DUT output
//   against it and then advances the model to the next rising edge.
// -----------------------------------------------------------------------------
module tb_stream_demux;

   localparam int W = 8;
   localparam int CW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [W-1:0]  IN_DATA;
   logic          IN_VALID;
   logic          IN_READY;
   logic          SEL;
   logic [W-1:0]  A_DATA;
   logic          A_VALID;
   logic          A_READY;
   logic [W-1:0]  B_DATA;
   logic          B_VALID;
   logic          B_READY;
   logic [CW-1:0] CNT_A;
   logic [CW-1:0] CNT_B;

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------------- clock
   always #5 CLK = ~CLK;

   stream_demux #(.WIDTH(W), .CNT_W(CW)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN_DATA  (IN_DATA),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .SEL      (SEL),
      .A_DATA   (A_DATA),
      .A_VALID  (A_VALID),
      .A_READY  (A_READY),
      .B_DATA   (B_DATA),
      .B_VALID  (B_VALID),
      .B_READY  (B_READY),
      .CNT_A    (CNT_A),
      .CNT_B    (CNT_B)
   );

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- driver
   // Inputs change 1 time unit after the rising edge and are held through the
   // next rising edge.
   task automatic drive(input logic rst, input logic v, input logic s,
                        input logic [W-1:0] d, input logic ar, input logic br);
      @(posedge CLK);
      #1;
      RST      = rst;
      IN_VALID = v;
      SEL      = s;
      IN_DATA  = d;
      A_READY  = ar;
      B_READY  = br;
   endtask

   // ---------------------------------------------------------------- scoreboard
   logic [W-1:0]  exp_a[$];
   logic [W-1:0]  exp_b[$];
   logic [W-1:0]  hold_a = '0;
   logic [W-1:0]  hold_b = '0;
   logic [CW-1:0] m_cnt_a = '0;
   logic [CW-1:0] m_cnt_b = '0;

   always @(negedge CLK) begin
      logic exp_rdy;
      logic pa, pb;
      exp_rdy = RST ? 1'b0 : (SEL ? (exp_b.size() != 2) : (exp_a.size() != 2));
      assert (!(IN_VALID === 1'b1 && $isunknown(SEL)))
         else $error("protocol violation: SEL unknown with IN_VALID high");
      check("in_ready", {31'd0, IN_READY}, {31'd0, exp_rdy});
      check("a_valid",  {31'd0, A_VALID},  {31'd0, exp_a.size() != 0});
      check("b_valid",  {31'd0, B_VALID},  {31'd0, exp_b.size() != 0});
      check("a_data",   {24'd0, A_DATA},   {24'd0, (exp_a.size() != 0) ? exp_a[0] : hold_a});
      check("b_data",   {24'd0, B_DATA},   {24'd0, (exp_b.size() != 0) ? exp_b[0] : hold_b});
      check("cnt_a",    {24'd0, CNT_A},    {24'd0, m_cnt_a});
      check("cnt_b",    {24'd0, CNT_B},    {24'd0, m_cnt_b});
      // Advance the model to what the coming rising edge produces.
      if (RST) begin
         exp_a.delete();
         exp_b.delete();
         hold_a  = '0;
         hold_b  = '0;
         m_cnt_a = '0;
         m_cnt_b = '0;
      end else begin
         pa = (exp_a.size() != 0) && A_READY;
         pb = (exp_b.size() != 0) && B_READY;
         if (pa) begin
            hold_a = exp_a.pop_front();
            m_cnt_a++;
         end
         if (pb) begin
            hold_b = exp_b.pop_front();
            m_cnt_b++;
         end
         if (IN_VALID && exp_rdy) begin
            if (SEL) exp_b.push_back(IN_DATA);
            else     exp_a.push_back(IN_DATA);
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      RST = 1'b1; IN_VALID = 1'b0; SEL = 1'b0; IN_DATA = '0;
      A_READY = 1'b0; B_READY = 1'b0;
      drive(1, 0, 0, 8'h00, 0, 0);
      drive(1, 0, 0, 8'h00, 0, 0);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("init_in_ready", {31'd0, IN_READY}, 32'd1);
      check("init_cnt_a", {24'd0, CNT_A}, 32'd0);

      // Basic steering: A word valid for exactly one cycle, B one cycle later.
      drive(0, 1, 0, 8'h11, 1, 1);
      drive(0, 1, 1, 8'h22, 1, 1);
      @(negedge CLK);
      check("t2_a_valid", {31'd0, A_VALID}, 32'd1);
      check("t2_a_data", {24'd0, A_DATA}, 32'h11);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t2_a_valid_gone", {31'd0, A_VALID}, 32'd0);
      check("t2_b_data", {24'd0, B_DATA}, 32'h22);
      check("t2_cnt_a", {24'd0, CNT_A}, 32'd1);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t2_cnt_b", {24'd0, CNT_B}, 32'd1);

      // Backpressure on A, isolation of B.
      drive(0, 1, 0, 8'hA1, 0, 1);
      drive(0, 1, 0, 8'hA2, 0, 1);
      drive(0, 1, 0, 8'hA3, 0, 1);
      @(negedge CLK);
      check("t3_a3_refused", {31'd0, IN_READY}, 32'd0);
      check("t3_a_head", {24'd0, A_DATA}, 32'hA1);
      drive(0, 1, 1, 8'hB1, 0, 1);
      @(negedge CLK);
      check("t3_b1_ready", {31'd0, IN_READY}, 32'd1);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t3_b_data", {24'd0, B_DATA}, 32'hB1);
      check("t3_a_still_a1", {24'd0, A_DATA}, 32'hA1);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t3_a_second", {24'd0, A_DATA}, 32'hA2);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      // Two deliveries on A on top of the one from the steering test.
      check("t3_cnt_a", {24'd0, CNT_A}, 32'd3);
      check("t3_cnt_b", {24'd0, CNT_B}, 32'd2);

      // Simultaneous push and pop on A while it holds one word.
      drive(0, 1, 0, 8'h05, 0, 1);
      drive(0, 1, 0, 8'h06, 1, 1);
      @(negedge CLK);
      check("t4_a_data_05", {24'd0, A_DATA}, 32'h05);
      drive(0, 0, 0, 8'h00, 0, 1);
      @(negedge CLK);
      check("t4_a_data_06", {24'd0, A_DATA}, 32'h06);
      check("t4_a_valid", {31'd0, A_VALID}, 32'd1);
      check("t4_cnt_a", {24'd0, CNT_A}, 32'd4);
      drive(0, 0, 0, 8'h00, 1, 1);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t4_a_empty", {31'd0, A_VALID}, 32'd0);
      check("t4_cnt_a_end", {24'd0, CNT_A}, 32'd5);

      // Reset mid-stream with both buffers full; handshakes during reset ignored.
      drive(0, 1, 0, 8'hC1, 0, 0);
      drive(0, 1, 0, 8'hC2, 0, 0);
      drive(0, 1, 1, 8'hD1, 0, 0);
      drive(0, 1, 1, 8'hD2, 0, 0);
      drive(0, 0, 0, 8'h00, 0, 0);
      @(negedge CLK);
      check("t1_a_full", {31'd0, IN_READY}, 32'd0);
      drive(1, 1, 0, 8'hE1, 1, 1);
      @(negedge CLK);
      check("t1_rst_ready", {31'd0, IN_READY}, 32'd0);
      drive(1, 1, 1, 8'hE2, 1, 1);
      @(negedge CLK);
      check("t1_a_valid", {31'd0, A_VALID}, 32'd0);
      check("t1_b_valid", {31'd0, B_VALID}, 32'd0);
      check("t1_a_data", {24'd0, A_DATA}, 32'h00);
      check("t1_b_data", {24'd0, B_DATA}, 32'h00);
      check("t1_cnt_a", {24'd0, CNT_A}, 32'd0);
      check("t1_cnt_b", {24'd0, CNT_B}, 32'd0);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t1_ready_after", {31'd0, IN_READY}, 32'd1);
      check("t1_no_ghost_a", {31'd0, A_VALID}, 32'd0);

      // Full throughput on B: 300 words, counter wraps to 44.
      for (int i = 0; i < 300; i++) begin
         drive(0, 1, 1, W'(i), 1, 1);
         @(negedge CLK);
         check("t5_ready", {31'd0, IN_READY}, 32'd1);
      end
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t5_last_word", {24'd0, B_DATA}, 32'd43);
      drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t5_cnt_b_wrap", {24'd0, CNT_B}, 32'd44);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 1, 1);
      @(negedge CLK);
      check("t6_a_drained", exp_a.size(), 32'd0);
      check("t6_b_drained", exp_b.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1:2 demultiplexer for the datapath. It steers each accepted input word to output port A (SEL=0) or port B (SEL=1).
- Each port has a valid/ready handshake and an independent 2-entry buffer. One stalled port therefore never corrupts, drops or reorders words bound for the other port.
- Per-port delivered-word counters are provided for bench checking and debug.

Parameters:
- WIDTH, 8, data word width in bits
- CNT_W, 8, width of per-port delivered-word counters (wrap modulo 2^CNT_W)

Ports:
- CLK  input  1  rising-edge clock; single clock domain
- RST  input  1  synchronous, active-high reset, sampled on CLK rising edge
- IN_DATA  input  WIDTH  input word
- IN_VALID  input  1  input word present
- IN_READY  output  1  block accepts the word this cycle
- SEL  input  1  destination select: 0 -> A, 1 -> B; must be known (not X/Z) whenever IN_VALID=1
- A_DATA  output  WIDTH  head word of port A buffer
- A_VALID  output  1  port A holds a word
- A_READY  input  1  port A consumer takes the word
- B_DATA  output  WIDTH  head word of port B buffer
- B_VALID  output  1  port B holds a word
- B_READY  input  1  port B consumer takes the word
- CNT_A  output  CNT_W  words delivered on port A (A_VALID & A_READY)
- CNT_B  output  CNT_W  words delivered on port B

Behaviour:
- Handshake
  - Input transfer occurs when IN_VALID & IN_READY are both high at a CLK edge.
  - Output transfer on port X occurs when X_VALID & X_READY are both high at a CLK edge.
- Per-port buffer: 2-entry FIFO with occupancy states EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, with the head replaced by the pushed word.
  - FULL: pop -> ONE, with the second entry moved to the head. Push is impossible because IN_READY is low.
- X_VALID = (occupancy != 0), registered. X_DATA is the head entry, registered. X_DATA holds its last value when X_VALID=0.
- IN_READY
  - Equals SEL ? (B occupancy != FULL) : (A occupancy != FULL).
  - It is a function of registered state and SEL only. It never depends combinationally on A_READY or B_READY.
  - IN_READY is forced 0 while RST=1.
- Latency
  - A word accepted at edge N into an EMPTY buffer appears with X_VALID=1 after edge N. Latency is 1 cycle.
  - There is no combinational path from any IN_* to any A_*/B_* output.
- Throughput: with X_READY held 1, a port sustains 1 word/cycle indefinitely. Occupancy never exceeds 1 in that case.
- Ordering
  - Words on each port emerge in acceptance order.
  - No ordering is defined between ports.
  - A port whose ready is held 0 fills to FULL. After that, only input words with SEL pointing at the other port are accepted.
- Simultaneous events
  - A push and a pop on the same port at the same edge are both honoured.
  - A push to A and a pop from B at the same edge are independent.
- Counters
  - CNT_X increments by 1 on each port-X output transfer and wraps from 2^CNT_W-1 to 0.
  - No counter increments on input acceptance.
- Reset values, applied at the first CLK edge with RST=1, including mid-transfer:
  - occupancy of both buffers = 0
  - A_VALID = B_VALID = 0
  - A_DATA = B_DATA = 0
  - CNT_A = CNT_B = 0
  - IN_READY = 0
  - Buffered words are discarded.
  - Handshakes presented during reset are ignored and are neither counted nor buffered.
  - IN_READY rises in the first cycle after RST deasserts, given IN_VALID/SEL.
- SEL=X with IN_VALID=1 is a protocol violation. The output is undefined, and the bench flags it with an assertion.

Test Plan:
1. Reset behaviour: Assert RST for 2 cycles mid-stream with both buffers FULL -> after reset A_VALID=B_VALID=0, A_DATA=B_DATA=0, CNT_A=CNT_B=0; IN_READY=0 during reset and 1 in the first cycle after it.
2. Basic steering: A_READY=B_READY=1; send 8'h11 (SEL=0), 8'h22 (SEL=1) on consecutive cycles -> A_DATA=8'h11 with A_VALID for exactly 1 cycle starting 1 cycle after acceptance; B_DATA=8'h22 one cycle later; CNT_A=1, CNT_B=1.
3. Backpressure and isolation:
   - Hold A_READY=0; send 8'hA1, 8'hA2, 8'hA3 with SEL=0 -> first two accepted, IN_READY=0 for 8'hA3.
   - Switch to SEL=1 and send 8'hB1 -> accepted and delivered on B.
   - Release A_READY -> A delivers 8'hA1 then 8'hA2 in order; CNT_A=2.
4. Simultaneous push/pop: port A in ONE state holding 8'h05; A_READY=1 and push 8'h06 to A at the same edge -> occupancy stays ONE, A_DATA=8'h06 next cycle, CNT_A increments by 1.
5. Full throughput: 300 back-to-back words to B with B_READY=1 and CNT_W=8 -> IN_READY never drops, outputs in order, CNT_B wraps to 300 mod 256 = 44.
6. Random: random SEL/IN_VALID/A_READY/B_READY for 10k cycles against a scoreboard (two queues) -> zero mismatches; CNT_A/CNT_B equal scoreboard pop counts mod 2^CNT_W.
